// File: rtl/omp_supp_arb_pkg.sv
// Shared types and helpers for the OMP support-set RAM arbiter.
package omp_supp_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_e;

  // Ceiling log2, floored at 1 so a pointer always has at least one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/omp_supp_arb_if.sv
// Requester / clear-control / RAM port bundle for the support-set arbiter.
interface omp_supp_arb_if #(
  parameter int NUM_REQ = 3,
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 7
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*AWIDTH-1:0] req_addr;
  logic [NUM_REQ*DWIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rd_valid;
  logic [DWIDTH-1:0]         rd_data;
  logic                      clr_start;
  logic                      clr_busy;
  logic                      clr_done;
  logic [AWIDTH-1:0]         ram_addr0;
  logic                      ram_ce0;
  logic [DWIDTH-1:0]         ram_d0;
  logic                      ram_we0;
  logic [DWIDTH-1:0]         ram_q0;

  // Arbiter side.
  modport slave (
    input  req, req_we, req_addr, req_wdata, clr_start, ram_q0,
    output gnt, rd_valid, rd_data, clr_busy, clr_done,
           ram_addr0, ram_ce0, ram_d0, ram_we0
  );

  // Engine / RAM side.
  modport master (
    output req, req_we, req_addr, req_wdata, clr_start, ram_q0,
    input  gnt, rd_valid, rd_data, clr_busy, clr_done,
           ram_addr0, ram_ce0, ram_d0, ram_we0
  );
endinterface

// File: rtl/omp_supp_arb_rr_pick.sv
// Round-robin picker: first set request at or after the pointer, wrapping.
module omp_supp_arb_rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int PW      = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [PW-1:0]      o_idx,
  output logic               o_any
);

  // Scan NUM_REQ slots starting at the pointer; first hit wins.
  always_comb begin
    int j;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(i_ptr) + k) % NUM_REQ;
      if (!o_any && i_req[j]) begin
        o_any    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/omp_supp_arb.sv
// Round-robin sharing of the single-port OMP support RAM, plus a clear sweep
// that writes CLR_VALUE to every word between iterations.
module omp_supp_arb
  import omp_supp_arb_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 7,
  parameter int MEM_SIZE  = 128,
  parameter int CLR_VALUE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  omp_supp_arb_if.slave         bus
);

  localparam int PW = clog2_min1(NUM_REQ);

  arb_state_e          r_state;
  logic [AWIDTH-1:0]   r_clr_cnt;
  logic [PW-1:0]       r_rr_ptr;
  logic [NUM_REQ-1:0]  r_rd_valid;
  logic                r_clr_done;

  logic [NUM_REQ-1:0]  w_pick_gnt;
  logic [PW-1:0]       w_idx;
  logic                w_any;
  logic                w_arb_en;
  logic                w_grant;
  logic                w_last;

  omp_supp_arb_rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
    .i_req (bus.req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // clr_start beats any request in the cycle it is seen; nothing is
  // granted while in reset or sweeping.
  assign w_arb_en = rst_n && (r_state == ST_IDLE) && !bus.clr_start;
  assign w_grant  = w_arb_en && w_any;
  assign w_last   = (r_clr_cnt == AWIDTH'(MEM_SIZE - 1));

  assign bus.gnt      = w_arb_en ? w_pick_gnt : '0;
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data  = bus.ram_q0;
  assign bus.clr_busy = (r_state == ST_CLEAR);
  assign bus.clr_done = r_clr_done;

  // RAM port mux: sweep owns the port in CLEAR, else the granted requester.
  always_comb begin
    bus.ram_ce0   = 1'b0;
    bus.ram_we0   = 1'b0;
    bus.ram_addr0 = '0;
    bus.ram_d0    = '0;
    if (rst_n && r_state == ST_CLEAR) begin
      bus.ram_ce0   = 1'b1;
      bus.ram_we0   = 1'b1;
      bus.ram_addr0 = r_clr_cnt;
      bus.ram_d0    = DWIDTH'(CLR_VALUE);
    end else if (w_grant) begin
      bus.ram_ce0   = 1'b1;
      bus.ram_we0   = bus.req_we[w_idx];
      bus.ram_addr0 = bus.req_addr[int'(w_idx)*AWIDTH +: AWIDTH];
      bus.ram_d0    = bus.req_wdata[int'(w_idx)*DWIDTH +: DWIDTH];
    end
  end

  // FSM, sweep counter, rr pointer and read-valid pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_clr_cnt  <= '0;
      r_rr_ptr   <= '0;
      r_rd_valid <= '0;
      r_clr_done <= 1'b0;
    end else begin
      r_clr_done <= 1'b0;
      r_rd_valid <= '0;
      if (w_grant) begin
        if (!bus.req_we[w_idx]) r_rd_valid[w_idx] <= 1'b1;
        r_rr_ptr <= (w_idx == PW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.clr_start) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
          end
        end
        ST_CLEAR: begin
          if (w_last) begin
            r_state    <= ST_IDLE;
            r_clr_cnt  <= '0;
            r_clr_done <= 1'b1;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
